// File: rtl/traffic_pkg.sv
// Shared phase codes, light encodings and default BCD durations used by
// traffic_phase_scheduler and its gap detectors.
package traffic_pkg;

    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YEL  = 3'd1,
        RED_AB = 3'd2,
        B_GRN  = 3'd3,
        B_YEL  = 3'd4,
        RED_BA = 3'd5
    } phase_t;

    localparam logic [1:0] LIGHT_RED = 2'b00;
    localparam logic [1:0] LIGHT_YEL = 2'b01;
    localparam logic [1:0] LIGHT_GRN = 2'b10;

    localparam logic [7:0] A_GREEN_DEF = 8'h30;
    localparam logic [7:0] B_GREEN_DEF = 8'h20;
    localparam logic [7:0] YELLOW_DEF  = 8'h05;
    localparam logic [7:0] ALLRED_DEF  = 8'h02;
    localparam int         GAP_CYC_DEF = 3;

    // Successor on countdown expiry; an all-red phase returns to the green it
    // just left when only that road is demanding.
    function automatic phase_t next_phase(input phase_t cur, input logic a_traffic,
                                          input logic b_traffic);
        phase_t nxt;
        case (cur)
            A_GRN:   nxt = A_YEL;
            A_YEL:   nxt = RED_AB;
            RED_AB:  nxt = (a_traffic && !b_traffic) ? A_GRN : B_GRN;
            B_GRN:   nxt = B_YEL;
            B_YEL:   nxt = RED_BA;
            default: nxt = (b_traffic && !a_traffic) ? B_GRN : A_GRN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_gap_detector.sv
// gap_detector: saturating count of consecutive no-traffic cycles on one road.
// gap is raised in the cycle that completes the GAP_CYC-th such cycle.
module gap_detector #(
    parameter int GAP_CYC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic traffic,
    input  logic clear,
    input  logic freeze,
    output logic gap
);

    localparam logic [3:0] THRESH = 4'(GAP_CYC - 1);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 4'd0;
        end else if (!freeze) begin
            if (traffic) begin
                count <= 4'd0;
            end else if (count != 4'hF) begin
                count <= count + 4'd1;
            end
        end
    end

    // Looks one cycle ahead so the yellow begins right after the last gap cycle.
    assign gap = !traffic && (count >= THRESH);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road phase sequencer driving a shared BCD countdown and the A/B lights.
// Define GAP_OUT_EN to compile in green gap-out via two gap_detector instances.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter logic [7:0] A_GREEN_T = A_GREEN_DEF,
    parameter logic [7:0] B_GREEN_T = B_GREEN_DEF,
    parameter logic [7:0] YELLOW_T  = YELLOW_DEF,
    parameter logic [7:0] ALLRED_T  = ALLRED_DEF,
    parameter int         GAP_CYC   = GAP_CYC_DEF
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       A_Traffic,
    input  logic       B_Traffic,
    input  logic       Hold,
    input  logic       cnt_zero,
    output logic       load,
    output logic [3:0] load_msb,
    output logic [3:0] load_lsb,
    output logic       cnt_en,
    output logic [2:0] phase,
    output logic [1:0] A_Light,
    output logic [1:0] B_Light
);

    if (GAP_CYC < 2 || GAP_CYC > 15) begin : g_gap_range
        $error("GAP_CYC must lie in 2..15");
    end

    phase_t     phase_q, phase_d;
    logic       pending_q, pending_d;
    logic       active_q;
    logic       gap_out;
    logic [7:0] duration;

`ifdef GAP_OUT_EN
    logic gap_a, gap_b;
    logic clear_a, clear_b;

    assign clear_a = !active_q || pending_q || (phase_q != A_GRN);
    assign clear_b = !active_q || pending_q || (phase_q != B_GRN);

    gap_detector #(.GAP_CYC(GAP_CYC)) u_gap_a (
        .clk     (CLK),
        .rst     (R),
        .traffic (A_Traffic),
        .clear   (clear_a),
        .freeze  (Hold),
        .gap     (gap_a)
    );

    gap_detector #(.GAP_CYC(GAP_CYC)) u_gap_b (
        .clk     (CLK),
        .rst     (R),
        .traffic (B_Traffic),
        .clear   (clear_b),
        .freeze  (Hold),
        .gap     (gap_b)
    );

    assign gap_out = ((phase_q == A_GRN) && gap_a && B_Traffic) ||
                     ((phase_q == B_GRN) && gap_b && A_Traffic);
`else
    assign gap_out = 1'b0;
`endif

    // active_q is low only in reset, so the first cycle after release is the
    // RED_BA load cycle without any extra reset-exit state.
    always_ff @(posedge CLK) begin
        if (R) begin
            phase_q   <= RED_BA;
            pending_q <= 1'b1;
            active_q  <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            pending_q <= pending_d;
            active_q  <= 1'b1;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        pending_d = pending_q;
        if (!active_q || Hold) begin
            phase_d   = phase_q;
        end else if (pending_q) begin
            pending_d = 1'b0;
        end else if (phase_q > RED_BA) begin
            phase_d   = RED_BA;
            pending_d = 1'b1;
        end else if (cnt_zero) begin
            phase_d   = next_phase(phase_q, A_Traffic, B_Traffic);
            pending_d = 1'b1;
        end else if (gap_out) begin
            phase_d   = (phase_q == A_GRN) ? A_YEL : B_YEL;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        case (phase_q)
            A_GRN:        duration = A_GREEN_T;
            B_GRN:        duration = B_GREEN_T;
            A_YEL, B_YEL: duration = YELLOW_T;
            default:      duration = ALLRED_T;
        endcase
    end

    always_comb begin
        A_Light = LIGHT_RED;
        B_Light = LIGHT_RED;
        case (phase_q)
            A_GRN:   A_Light = LIGHT_GRN;
            A_YEL:   A_Light = LIGHT_YEL;
            B_GRN:   B_Light = LIGHT_GRN;
            B_YEL:   B_Light = LIGHT_YEL;
            default: A_Light = LIGHT_RED;
        endcase
    end

    assign load                 = active_q && pending_q;
    assign cnt_en               = active_q && !pending_q && !Hold;
    assign {load_msb, load_lsb} = load ? duration : 8'h00;
    assign phase                = phase_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with a BCD countdown model
// closing the load/cnt_en/cnt_zero loop.
module tb_traffic_phase_scheduler;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;

    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic       a_traffic = 1'b1;
    logic       b_traffic = 1'b1;
    logic       hold = 1'b0;
    logic       cnt_zero;
    logic       load;
    logic [3:0] load_msb, load_lsb;
    logic       cnt_en;
    logic [2:0] phase;
    logic [1:0] a_light, b_light;

    logic [7:0] cnt = 8'h00;

    int checks = 0;
    int errors = 0;

    int exp_len [6];
    int exp_ph  [6];
    logic [1:0] exp_a [6];
    logic [1:0] exp_b [6];

    traffic_phase_scheduler dut (
        .CLK       (clk),
        .R         (r),
        .A_Traffic (a_traffic),
        .B_Traffic (b_traffic),
        .Hold      (hold),
        .cnt_zero  (cnt_zero),
        .load      (load),
        .load_msb  (load_msb),
        .load_lsb  (load_lsb),
        .cnt_en    (cnt_en),
        .phase     (phase),
        .A_Light   (a_light),
        .B_Light   (b_light)
    );

    always #5 clk = ~clk;

    // Standard two-digit BCD countdown the scheduler is designed to drive.
    always @(posedge clk) begin
        if (load)
            cnt <= {load_msb, load_lsb};
        else if (cnt_en && cnt != 8'h00)
            cnt <= (cnt[3:0] == 4'd0) ? {cnt[7:4] - 4'd1, 4'd9} : {cnt[7:4], cnt[3:0] - 4'd1};
    end
    assign cnt_zero = (cnt == 8'h00);

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [2:0] target, input int budget);
        int n;
        n = 0;
        while (phase !== target && n < budget) begin
            step();
            n++;
        end
    endtask

    // Cycles from the current one to the last cycle of the current phase.
    task automatic measure_phase(output int len);
        logic [2:0] p;
        p = phase;
        len = 1;
        while (len < 300) begin
            step();
            if (phase !== p) break;
            len++;
        end
    endtask

    // Leaves the bench in the first post-reset cycle (RED_BA load cycle).
    task automatic do_reset();
        r = 1'b1;
        hold = 1'b0;
        a_traffic = 1'b1;
        b_traffic = 1'b1;
        step();
        step();
        r = 1'b0;
        step();
    endtask

    task automatic test_reset();
        r = 1'b1;
        a_traffic = 1'b1;
        b_traffic = 1'b1;
        step();
        step();
        checks++; if (phase !== 3'd5) begin errors++; $display("[TB] FAIL reset_phase: got %0d expected 5", phase); end
        checks++; if (a_light !== RED || b_light !== RED) begin errors++; $display("[TB] FAIL reset_lights: got %b/%b expected 00/00", a_light, b_light); end
        checks++; if (load !== 1'b0) begin errors++; $display("[TB] FAIL reset_load: got %b expected 0", load); end
        checks++; if (cnt_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_cnt_en: got %b expected 0", cnt_en); end
        checks++; if ({load_msb, load_lsb} !== 8'h00) begin errors++; $display("[TB] FAIL reset_digits: got %h expected 00", {load_msb, load_lsb}); end
        r = 1'b0;
        step();
        checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_load: got %b expected 1", load); end
        checks++; if ({load_msb, load_lsb} !== 8'h02) begin errors++; $display("[TB] FAIL post_reset_digits: got %h expected 02", {load_msb, load_lsb}); end
        checks++; if (cnt_en !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_cnt_en: got %b expected 0", cnt_en); end
        step();
        step();
        step();
        checks++; if (phase !== 3'd5) begin errors++; $display("[TB] FAIL red_ba_cycle3: got %0d expected 5", phase); end
        step();
        checks++; if (phase !== 3'd0) begin errors++; $display("[TB] FAIL a_green_entry: got %0d expected 0", phase); end
        checks++; if (load !== 1'b1 || {load_msb, load_lsb} !== 8'h30) begin errors++; $display("[TB] FAIL a_green_load: got %b/%h expected 1/30", load, {load_msb, load_lsb}); end
        checks++; if (a_light !== GRN || b_light !== RED) begin errors++; $display("[TB] FAIL a_green_lights: got %b/%b expected 10/00", a_light, b_light); end
    endtask

    task automatic test_full_cycle();
        int len;
        exp_len = '{32, 7, 4, 22, 7, 4};
        exp_ph  = '{0, 1, 2, 3, 4, 5};
        exp_a   = '{GRN, YEL, RED, RED, RED, RED};
        exp_b   = '{RED, RED, RED, GRN, YEL, RED};
        do_reset();
        wait_phase(3'd0, 20);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (phase !== 3'(exp_ph[i])) begin errors++; $display("[TB] FAIL cycle_phase[%0d]: got %0d expected %0d", i, phase, exp_ph[i]); end
                checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL cycle_entry_load[%0d]: got %b expected 1", i, load); end
                checks++; if (a_light !== exp_a[i] || b_light !== exp_b[i]) begin errors++; $display("[TB] FAIL cycle_lights[%0d]: got %b/%b expected %b/%b", i, a_light, b_light, exp_a[i], exp_b[i]); end
                measure_phase(len);
                checks++; if (len !== exp_len[i]) begin errors++; $display("[TB] FAIL cycle_len[%0d]: got %0d expected %0d", i, len, exp_len[i]); end
            end
        end
        checks++; if (phase !== 3'd0) begin errors++; $display("[TB] FAIL cycle_wrap: got %0d expected 0", phase); end
    endtask

    task automatic test_skip();
        logic [2:0] prev;
        int skips;
        skips = 0;
        do_reset();
        a_traffic = 1'b1;
        b_traffic = 1'b0;
        prev = phase;
        for (int i = 0; i < 150; i++) begin
            step();
            checks++; if (b_light !== RED) begin errors++; $display("[TB] FAIL skip_b_light@%0d: got %b expected 00", i + 1, b_light); end
            if (prev == 3'd2 && phase !== 3'd2) begin
                skips++;
                checks++; if (phase !== 3'd0) begin errors++; $display("[TB] FAIL skip_target: got %0d expected 0", phase); end
            end
            prev = phase;
        end
        checks++; if (skips !== 3) begin errors++; $display("[TB] FAIL skip_count: got %0d expected 3", skips); end
        b_traffic = 1'b1;
    endtask

    task automatic test_gap_out();
        int len;
        do_reset();
        wait_phase(3'd0, 20);
        checks++; if (phase !== 3'd0 || load !== 1'b1) begin errors++; $display("[TB] FAIL gap_start: got %0d/%b expected 0/1", phase, load); end
        for (int i = 0; i < 10; i++) step();
        a_traffic = 1'b0;
        b_traffic = 1'b1;
`ifdef GAP_OUT_EN
        step();
        step();
        checks++; if (phase !== 3'd0) begin errors++; $display("[TB] FAIL gap_not_early: got %0d expected 0", phase); end
        step();
        checks++; if (phase !== 3'd1) begin errors++; $display("[TB] FAIL gap_yellow: got %0d expected 1", phase); end
        checks++; if (load !== 1'b1 || {load_msb, load_lsb} !== 8'h05) begin errors++; $display("[TB] FAIL gap_yellow_load: got %b/%h expected 1/05", load, {load_msb, load_lsb}); end
        measure_phase(len);
        checks++; if (len !== 7) begin errors++; $display("[TB] FAIL gap_yellow_len: got %0d expected 7", len); end
`else
        measure_phase(len);
        checks++; if (10 + len !== 32) begin errors++; $display("[TB] FAIL green_full_len: got %0d expected 32", 10 + len); end
        checks++; if (phase !== 3'd1) begin errors++; $display("[TB] FAIL green_then_yellow: got %0d expected 1", phase); end
`endif
        a_traffic = 1'b1;
    endtask

    task automatic test_hold();
        int len;
        do_reset();
        wait_phase(3'd3, 200);
        checks++; if (phase !== 3'd3 || load !== 1'b1) begin errors++; $display("[TB] FAIL hold_b_entry: got %0d/%b expected 3/1", phase, load); end
        for (int i = 0; i < 5; i++) step();
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) step();
            #1;
            checks++; if (phase !== 3'd3 || b_light !== GRN || a_light !== RED) begin errors++; $display("[TB] FAIL hold_frozen@%0d: got %0d %b/%b expected 3 00/10", i, phase, a_light, b_light); end
            checks++; if (cnt_en !== 1'b0 || load !== 1'b0) begin errors++; $display("[TB] FAIL hold_cnt_en@%0d: got %b/%b expected 0/0", i, cnt_en, load); end
        end
        step();
        hold = 1'b0;
        measure_phase(len);
        checks++; if (25 + len !== 42) begin errors++; $display("[TB] FAIL hold_b_len: got %0d expected 42", 25 + len); end
        checks++; if (phase !== 3'd4) begin errors++; $display("[TB] FAIL hold_then_yellow: got %0d expected 4", phase); end
    endtask

    task automatic test_hold_load();
        int pulses;
        logic prev_load;
        int len;
        do_reset();
        pulses = 1;
        prev_load = load;
        checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL hload_start: got %b expected 1", load); end
        hold = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            if (load && !prev_load) pulses++;
            prev_load = load;
            checks++; if (load !== 1'b1 || cnt_en !== 1'b0) begin errors++; $display("[TB] FAIL hload_held@%0d: got %b/%b expected 1/0", i, load, cnt_en); end
        end
        step();
        hold = 1'b0;
        if (load && !prev_load) pulses++;
        prev_load = load;
        checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL hload_release: got %b expected 1", load); end
        step();
        if (load && !prev_load) pulses++;
        checks++; if (load !== 1'b0) begin errors++; $display("[TB] FAIL hload_done: got %b expected 0", load); end
        measure_phase(len);
        checks++; if (4 + len !== 7) begin errors++; $display("[TB] FAIL hload_a_entry_cycle: got %0d expected 7", 4 + len); end
        checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL hload_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        wait_phase(3'd1, 100);
        checks++; if (phase !== 3'd1) begin errors++; $display("[TB] FAIL mreset_yellow: got %0d expected 1", phase); end
        step();
        step();
        r = 1'b1;
        step();
        checks++; if (phase !== 3'd5 || a_light !== RED || b_light !== RED) begin errors++; $display("[TB] FAIL mreset_state: got %0d %b/%b expected 5 00/00", phase, a_light, b_light); end
        checks++; if (load !== 1'b0 || cnt_en !== 1'b0) begin errors++; $display("[TB] FAIL mreset_outputs: got %b/%b expected 0/0", load, cnt_en); end
        r = 1'b0;
        step();
        checks++; if (load !== 1'b1 || {load_msb, load_lsb} !== 8'h02) begin errors++; $display("[TB] FAIL mreset_reload: got %b/%h expected 1/02", load, {load_msb, load_lsb}); end
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_skip();
        test_gap_out();
        test_hold();
        test_hold_load();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
